// File: rtl/capture_buffer_if.sv
// Bus bundle between the capture buffer and its probe/readout side.
interface capture_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    // Probe and control inputs to the buffer
    logic                  arm;
    logic                  sample_en;
    logic [DATA_WIDTH-1:0] data;
    logic                  trigger;
    logic [ADDR_WIDTH-1:0] post_count;
    logic [ADDR_WIDTH-1:0] raddr;

    // Readout and status outputs from the buffer
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  primed;
    logic                  capturing;
    logic                  triggered;
    logic                  done;

    // Probe/readout side: drives controls, observes status
    modport master (
        output arm, sample_en, data, trigger, post_count, raddr,
        input  rdata, waddr, trig_addr, start_addr,
               primed, capturing, triggered, done
    );

    // Buffer side
    modport slave (
        input  arm, sample_en, data, trigger, post_count, raddr,
        output rdata, waddr, trig_addr, start_addr,
               primed, capturing, triggered, done
    );
endinterface

// File: rtl/capture_buffer.sv
// Trigger-based circular sample buffer for the internal logic analyzer.
// Captures continuously while armed, counts post-trigger samples after a
// trigger, then freezes so the readout path can drain the memory.
module capture_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input logic              clk,
    input logic              reset,
    capture_buffer_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRETRIG  = 2'd1,
        POSTTRIG = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic                  primed_q, primed_d;
    logic                  triggered_q, triggered_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;

    // Write qualifier: arm and reset both win over a same-cycle sample
    always_comb begin
        wr_en = !reset && !bus.arm && bus.sample_en &&
                (state_q == PRETRIG || state_q == POSTTRIG);
    end

    // Next-state, pointer and flag logic
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        waddr_d     = waddr_q;
        trig_addr_d = trig_addr_q;
        remaining_d = remaining_q;
        primed_d    = primed_q;
        triggered_d = triggered_q;
        rdata_d     = mem[bus.raddr];

        if (bus.arm) begin
            state_d     = PRETRIG;
            waddr_d     = '0;
            primed_d    = 1'b0;
            triggered_d = 1'b0;
        end else if (wr_en) begin
            waddr_d = waddr_q + ADDR_WIDTH'(1);
            if (waddr_q == '1) begin
                primed_d = 1'b1;
            end
            unique case (state_q)
                PRETRIG: begin
                    if (bus.trigger) begin
                        trig_addr_d = waddr_q;
                        triggered_d = 1'b1;
                        remaining_d = bus.post_count;
                        state_d     = (bus.post_count == '0) ? DONE : POSTTRIG;
                    end
                end
                POSTTRIG: begin
                    remaining_d = remaining_q - ADDR_WIDTH'(1);
                    if (remaining_q == ADDR_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            trig_addr_q <= '0;
            remaining_q <= '0;
            primed_q    <= 1'b0;
            triggered_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            trig_addr_q <= trig_addr_d;
            remaining_q <= remaining_d;
            primed_q    <= primed_d;
            triggered_q <= triggered_d;
            rdata_q     <= rdata_d;
        end
    end

    // Sample memory; the registered read above sees the pre-write contents
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset so it maps onto plain RAM; readers rely on the address flags instead.
        if (wr_en) begin
            mem[waddr_q] <= bus.data;
        end
    end

    // Status outputs
    assign bus.rdata      = rdata_q;
    assign bus.waddr      = waddr_q;
    assign bus.trig_addr  = trig_addr_q;
    assign bus.start_addr = primed_q ? waddr_q : '0;
    assign bus.primed     = primed_q;
    assign bus.capturing  = (state_q == PRETRIG) || (state_q == POSTTRIG);
    assign bus.triggered  = triggered_q;
    assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: a driver applies directed and random
// stimulus and pushes the reference model's prediction; a monitor pops and
// compares after each clock edge.
module tb_capture_buffer;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;

    capture_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [DW-1:0] rdata;
        bit            rdata_known;
        logic [AW-1:0] waddr;
        logic [AW-1:0] trig_addr;
        logic [AW-1:0] start_addr;
        bit            primed;
        bit            capturing;
        bit            triggered;
        bit            done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: "is armed", "has frozen", sample counts as integers
    bit            m_armed, m_frozen, m_trig_seen, m_full;
    int            m_wr, m_tpos, m_left;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit a, input bit se, input logic [DW-1:0] d,
                              input bit tr, input int pc, input int ra, output exp_t e);
        if (rst) begin
            m_armed = 0; m_frozen = 0; m_trig_seen = 0; m_full = 0;
            m_wr = 0; m_tpos = 0; m_left = 0;
            e.rdata = '0;
            e.rdata_known = 1;
        end else begin
            e.rdata = m_mem[ra];
            e.rdata_known = m_known[ra];
            if (a) begin
                m_armed = 1; m_frozen = 0; m_trig_seen = 0; m_full = 0; m_wr = 0;
            end else if (m_armed && !m_frozen && se) begin
                m_mem[m_wr] = d;
                m_known[m_wr] = 1;
                if (m_wr == DEPTH - 1) m_full = 1;
                if (!m_trig_seen) begin
                    if (tr) begin
                        m_trig_seen = 1;
                        m_tpos = m_wr;
                        m_left = pc;
                        if (pc == 0) m_frozen = 1;
                    end
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_frozen = 1;
                end
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
        e.waddr      = AW'(m_wr);
        e.trig_addr  = AW'(m_tpos);
        e.primed     = m_full;
        e.start_addr = m_full ? AW'(m_wr) : '0;
        e.capturing  = m_armed && !m_frozen;
        e.triggered  = m_trig_seen;
        e.done       = m_frozen;
    endtask

    // Drive one cycle of stimulus and record the prediction for its edge
    task automatic cycle(input bit rst, input bit a, input bit se, input logic [DW-1:0] d,
                         input bit tr, input int pc, input int ra);
        exp_t e;
        @(negedge clk);
        reset          = rst;
        bus.arm        = a;
        bus.sample_en  = se;
        bus.data       = d;
        bus.trigger    = tr;
        bus.post_count = AW'(pc);
        bus.raddr      = AW'(ra);
        model_step(rst, a, se, d, tr, pc, ra, e);
        exp_q.push_back(e);
    endtask

    task automatic sample(input logic [DW-1:0] d, input bit tr, input int pc);
        cycle(0, 0, 1, d, tr, pc, 0);
    endtask

    task automatic read(input int ra);
        cycle(0, 0, 0, 8'h00, 0, 0, ra);
    endtask

    task automatic do_arm();
        cycle(0, 1, 1, 8'hEE, 1, 0, 0);
    endtask

    // Monitor: compare every prediction shortly after its clock edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.rdata_known) check("rdata", 32'(bus.rdata), 32'(e.rdata));
            check("waddr",      32'(bus.waddr),      32'(e.waddr));
            check("trig_addr",  32'(bus.trig_addr),  32'(e.trig_addr));
            check("start_addr", 32'(bus.start_addr), 32'(e.start_addr));
            check("primed",     32'(bus.primed),     32'(e.primed));
            check("capturing",  32'(bus.capturing),  32'(e.capturing));
            check("triggered",  32'(bus.triggered),  32'(e.triggered));
            check("done",       32'(bus.done),       32'(e.done));
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 0;
            m_mem[i]   = '0;
        end
        reset = 1'b1;
        bus.arm = 0; bus.sample_en = 0; bus.data = '0; bus.trigger = 0;
        bus.post_count = '0; bus.raddr = '0;

        // Reset with samples offered, then idle samples that must not write
        cycle(1, 0, 1, 8'h55, 0, 0, 0);
        cycle(1, 0, 1, 8'hAA, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, DW'(i[0] ? 8'h55 : 8'hAA), 0, 0, i);

        // Pre-trigger wrap: 20 samples, no trigger, then readback
        do_arm();
        for (int i = 1; i <= 20; i++) sample(DW'(i), 0, 0);
        for (int i = 0; i <= 5; i++) read(i);

        // Trigger on data=6 with post_count=3, extra samples after freeze
        do_arm();
        for (int i = 1; i <= 10; i++) sample(DW'(i), i == 6, 3);
        for (int i = 4; i <= 10; i++) read(i);

        // Ignored trigger (no sample_en), then post_count=0 trigger
        do_arm();
        sample(8'd1, 0, 0);
        sample(8'd2, 0, 0);
        cycle(0, 0, 0, 8'd3, 1, 0, 0);
        sample(8'd3, 0, 0);
        sample(8'd4, 1, 0);
        sample(8'd5, 0, 0);
        sample(8'd6, 1, 0);
        for (int i = 2; i <= 4; i++) read(i);

        // Re-arm during post-trigger capture, then a fresh trigger
        do_arm();
        for (int i = 1; i <= 4; i++) sample(DW'(i), 0, 0);
        sample(8'd5, 1, 5);
        for (int i = 6; i <= 8; i++) sample(DW'(i), 0, 0);
        do_arm();
        for (int i = 1; i <= 9; i++) sample(DW'(8'h40 + i), i == 3, 2);

        // Read-before-write collision at address 7
        do_arm();
        for (int i = 0; i < 7; i++) sample(DW'(8'h20 + i), 0, 0);
        sample(8'h11, 0, 0);
        for (int i = 0; i < 15; i++) sample(DW'(8'h30 + i), 0, 0);
        cycle(0, 0, 1, 8'hAA, 0, 0, 7);
        read(7);

        // Reset mid-capture: memory keeps its contents, idle does not write
        cycle(1, 0, 1, 8'hFF, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, DW'(8'hC0 + i), 1, 0, i);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 499) == 0,
                  $urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  DW'($urandom),
                  $urandom_range(0, 15) == 0,
                  int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, DEPTH - 1)));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/capture_buffer.md
Name: capture_buffer

Overview:
- Parametrised trigger-based sample buffer for the internal logic analyzer.
- Records probe data continuously into a circular memory while armed.
- On a trigger, records a programmable number of post-trigger samples, then freezes.
- Exposes a registered read port plus trigger address, oldest-sample address and status flags for the readout/UART path.

Parameters:
- DATA_WIDTH, 8, width of one captured sample.
- ADDR_WIDTH, 4, address width; buffer depth DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  input  1  capture clock.
- reset  input  1  synchronous, active-high reset.
- arm  input  1  one-cycle pulse; clears the write pointer and starts a new capture.
- sample_en  input  1  qualifies data as a valid sample this cycle.
- data  input  DATA_WIDTH  probe sample.
- trigger  input  1  trigger condition; honoured only together with sample_en.
- post_count  input  ADDR_WIDTH  samples to store after the trigger sample; sampled at trigger.
- raddr  input  ADDR_WIDTH  readback address.
- rdata  output  DATA_WIDTH  registered memory[raddr].
- waddr  output  ADDR_WIDTH  current write pointer.
- trig_addr  output  ADDR_WIDTH  address holding the trigger sample.
- start_addr  output  ADDR_WIDTH  oldest valid sample; equals waddr if primed, else 0.
- primed  output  1  all DEPTH locations written since arm.
- capturing  output  1  state is PRETRIG or POSTTRIG.
- triggered  output  1  trigger accepted since arm.
- done  output  1  state is DONE; memory frozen.

Behaviour:
- Reset values:
  - State IDLE.
  - waddr, trig_addr, remaining counter = 0.
  - primed, triggered, done, capturing = 0.
  - rdata = 0.
  - Memory contents are not reset.
- Clocking and timing:
  - Single clock domain.
  - All state, flags and counters update on posedge clk.
  - Reset has priority over everything.
- States:
  - IDLE: no writes.
  - PRETRIG: circular capture, waiting for trigger.
  - POSTTRIG: counting post-trigger samples.
  - DONE: frozen, readable.
- arm (any state, not in reset):
  - Next state PRETRIG; waddr <= 0; primed, triggered, done <= 0.
  - Any sample_en in the same cycle is ignored.
  - arm during POSTTRIG or DONE aborts or restarts cleanly.
- Write rule: in PRETRIG or POSTTRIG with sample_en=1:
  - memory[waddr] <= data.
  - waddr <= waddr + 1, wrapping modulo DEPTH.
  - No writes in IDLE or DONE, or when sample_en=0.
- primed:
  - Set on the cycle a write occurs at address DEPTH-1; sticky until arm or reset.
  - Never set in IDLE.
- PRETRIG, sample_en=1 and trigger=1:
  - The trigger sample is written.
  - trig_addr <= waddr; triggered <= 1; remaining <= post_count.
  - If post_count == 0: go to DONE.
  - Otherwise: go to POSTTRIG.
- trigger with sample_en=0 is ignored.
- trigger in POSTTRIG, DONE or IDLE is ignored.
- POSTTRIG, sample_en=1:
  - Write, then remaining <= remaining - 1.
  - When remaining == 1 at the write, go to DONE.
  - The last post-trigger sample lands at trig_addr + post_count (mod DEPTH).
- Overwrite guard: post_count max = DEPTH-1, so the trigger sample is never overwritten.
- DONE:
  - waddr holds at last write address + 1.
  - done = 1.
  - Stays in DONE until arm or reset.
- start_addr: combinational, primed ? waddr : 0.
  - The readout engine reads DEPTH entries from start_addr if primed.
  - Otherwise it reads entries 0 .. waddr-1.
- Read port:
  - rdata <= memory[raddr] every cycle; 1-cycle latency; active in all states.
  - Read and write to the same address in one cycle returns the old data (read-before-write).
- Arithmetic: all pointer arithmetic is ADDR_WIDTH-bit unsigned, wrap silent.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, sample_en=1 with data toggling.
   - Required: waddr=0, primed=0, done=0; after arm, memory is untouched.
2. Pre-trigger wrap: arm, then 20 samples data=1..20 with no trigger.
   - Required: primed rises on the cycle after the 16th write (data=16 at addr 15).
   - Required: waddr=4; readback addr 0..3 = 17..20 and addr 4 = 5; start_addr=4.
3. Trigger with post_count=3: arm, samples 1..10, trigger with data=6.
   - Required: trig_addr=5, done after the sample with data=9, waddr=9, triggered=1, primed=0.
   - Required: addr 8 = 9 and later samples are not written.
4. post_count=0 plus an ignored trigger: trigger asserted with sample_en=0 at data=3.
   - Required: no trigger taken.
   - Then trigger with sample_en=1 at data=4 (addr 3): done next cycle, waddr=4, trig_addr=3.
5. Re-arm mid-capture: arm during POSTTRIG with remaining=2.
   - Required: next cycle state PRETRIG, waddr=0, triggered=0, done=0, primed=0.
   - Required: a fresh trigger works normally.
6. Read latency and collision: in PRETRIG, raddr=waddr=7 while writing 0xAA over a location holding 0x11.
   - Required: rdata=0x11 next cycle, then 0xAA the cycle after.
